mmio_timer: RTL and testbench

MMIO_TIMER -- requirements
Module: mmio_timer

---
 rtl/timer_pkg.sv | 22 ++
 rtl/timer_prescaler.sv | 34 +++
 rtl/mmio_timer.sv | 137 +++++++++++++
 tb/tb_mmio_timer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and constants for the memory-mapped countdown timer.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Byte offsets from BASE_ADDR; the low two address bits are never decoded.
  localparam logic [31:0] OFF_CTRL     = 32'h0000_0000;
  localparam logic [31:0] OFF_LOAD     = 32'h0000_0004;
  localparam logic [31:0] OFF_COUNT    = 32'h0000_0008;
  localparam logic [31:0] OFF_STATUS   = 32'h0000_000C;
  localparam logic [31:0] OFF_PRESCALE = 32'h0000_0010;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_AUTO = 1;
  localparam int CTRL_IE   = 2;
  localparam int STATUS_TF = 0;

endpackage

// File: rtl/timer_prescaler.sv
// Free-running divider: one tick every period+1 enabled cycles, restartable via clr.
module timer_prescaler (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        en,
  input  logic [15:0] period,
  output logic        tick
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  // Compare with >= so a period lowered mid-count still ticks promptly.
  assign tick = en && (cnt_q >= period);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? 16'd0 : cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped countdown timer with prescaler, auto-reload and a W1C flag.
module mmio_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem1_ena,
  input  logic        mem1_rw,
  input  logic [31:0] mem1_daddr,
  input  logic [15:0] mem1_dout,
  output logic [15:0] mem1_din,
  output logic        irq
);
  import timer_pkg::*;

  state_e      state_q, state_d;
  logic        en_q, en_d, auto_q, auto_d, ie_q, ie_d, tf_q, tf_d, irq_q, irq_d;
  logic [15:0] load_q, load_d, count_q, count_d, prescale_q, prescale_d;

  logic        in_range, wr_en, tick, presc_clr, expire, run;
  logic        wr_ctrl, wr_load, wr_count, wr_status, wr_prescale;
  logic [29:0] word;
  logic        addr_lsb_unused;

  assign addr_lsb_unused = ^mem1_daddr[1:0];
  assign in_range    = mem1_daddr >= BASE_ADDR;
  assign word        = mem1_daddr[31:2] - BASE_ADDR[31:2];
  assign wr_en       = mem1_ena && mem1_rw && in_range;
  assign wr_ctrl     = wr_en && (word == OFF_CTRL[31:2]);
  assign wr_load     = wr_en && (word == OFF_LOAD[31:2]);
  assign wr_count    = wr_en && (word == OFF_COUNT[31:2]);
  assign wr_status   = wr_en && (word == OFF_STATUS[31:2]);
  assign wr_prescale = wr_en && (word == OFF_PRESCALE[31:2]);
  assign run         = (state_q == ST_RUN);

  timer_prescaler u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .clr    (presc_clr),
    .en     (run),
    .period (prescale_q),
    .tick   (tick)
  );

  // NOTE: every signal gets its hold value first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    en_d       = en_q;
    auto_d     = auto_q;
    ie_d       = ie_q;
    load_d     = load_q;
    count_d    = count_q;
    prescale_d = prescale_q;
    tf_d       = tf_q;
    irq_d      = tf_q & ie_q;
    presc_clr  = 1'b0;
    expire     = 1'b0;

    // A stopping CTRL write freezes COUNT, so it also swallows a same-cycle tick.
    if (run && tick && !(wr_ctrl && !mem1_dout[CTRL_EN])) begin
      if (count_q != 16'd0) begin
        count_d = count_q - 16'd1;
      end else begin
        expire = 1'b1;
        if (auto_q) begin
          count_d = load_q;
        end else begin
          state_d = ST_DONE;
          en_d    = 1'b0;
        end
      end
    end

    if (wr_ctrl) begin
      en_d   = mem1_dout[CTRL_EN];
      auto_d = mem1_dout[CTRL_AUTO];
      ie_d   = mem1_dout[CTRL_IE];
      if (!mem1_dout[CTRL_EN]) begin
        state_d = ST_IDLE;
      end else if (!run) begin
        state_d   = ST_RUN;
        count_d   = load_q;
        presc_clr = 1'b1;
      end else begin
        state_d = ST_RUN;
      end
    end

    if (wr_load)     load_d     = mem1_dout;
    if (wr_count)    count_d    = mem1_dout;
    if (wr_prescale) prescale_d = mem1_dout;
    if (wr_status && mem1_dout[STATUS_TF]) tf_d = 1'b0;
    if (expire)      tf_d       = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so all of them sample the same pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      en_q       <= 1'b0;
      auto_q     <= 1'b0;
      ie_q       <= 1'b0;
      load_q     <= '0;
      count_q    <= '0;
      prescale_q <= '0;
      tf_q       <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      auto_q     <= auto_d;
      ie_q       <= ie_d;
      load_q     <= load_d;
      count_q    <= count_d;
      prescale_q <= prescale_d;
      tf_q       <= tf_d;
      irq_q      <= irq_d;
    end
  end

  always_comb begin
    mem1_din = '0;
    if (mem1_ena && in_range) begin
      case (word)
        OFF_CTRL[31:2]:     mem1_din = {13'd0, ie_q, auto_q, en_q};
        OFF_LOAD[31:2]:     mem1_din = load_q;
        OFF_COUNT[31:2]:    mem1_din = count_q;
        OFF_STATUS[31:2]:   mem1_din = {15'd0, tf_q};
        OFF_PRESCALE[31:2]: mem1_din = prescale_q;
        default:            mem1_din = '0;
      endcase
    end
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_mmio_timer.sv
// Scoreboard bench for mmio_timer: directed corner cases, then random traffic against a register-level model.
module tb_mmio_timer;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem1_ena;
  logic        mem1_rw;
  logic [31:0] mem1_daddr;
  logic [15:0] mem1_dout;
  logic [15:0] mem1_din;
  logic        irq;

  mmio_timer #(.BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem1_ena   (mem1_ena),
    .mem1_rw    (mem1_rw),
    .mem1_daddr (mem1_daddr),
    .mem1_dout  (mem1_dout),
    .mem1_din   (mem1_din),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] rdata;
    logic        irq;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: registers as plain values, "running" flag, cycles since last tick.
  bit          m_en, m_auto, m_ie, m_tf, m_irq, m_run;
  logic [15:0] m_load, m_count, m_presc;
  int          m_since;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  function automatic logic [15:0] m_read(input logic [31:0] a);
    logic [31:0] off;
    if (a < BASE) return 16'h0;
    off = (a - BASE) >> 2;
    case (off)
      0:       return {13'd0, m_ie, m_auto, m_en};
      1:       return m_load;
      2:       return m_count;
      3:       return {15'd0, m_tf};
      4:       return m_presc;
      default: return 16'h0;
    endcase
  endfunction

  task automatic m_clear();
    m_en = 0; m_auto = 0; m_ie = 0; m_tf = 0; m_irq = 0; m_run = 0;
    m_load = 0; m_count = 0; m_presc = 0; m_since = 0;
  endtask

  task automatic m_step(input bit ena, input bit rw, input logic [31:0] a,
                        input logic [15:0] d, input bit rst);
    int          idx;
    logic [31:0] off;
    bit          tick, expire, was_run, next_irq;
    if (rst) begin
      m_clear();
      return;
    end
    off = (a - BASE) >> 2;
    idx = (ena && rw && a >= BASE && off <= 4) ? int'(off) : -1;
    next_irq = m_tf && m_ie;
    was_run  = m_run;
    tick     = m_run && (m_since >= int'(m_presc));
    expire   = 0;
    if (m_run) m_since = tick ? 0 : m_since + 1;
    if (tick && !(idx == 0 && !d[0])) begin
      if (m_count != 0) m_count = m_count - 16'd1;
      else begin
        expire = 1;
        if (m_auto) m_count = m_load;
        else begin m_run = 0; m_en = 0; end
      end
    end
    if (idx == 0) begin
      m_en = d[0]; m_auto = d[1]; m_ie = d[2];
      if (!d[0]) m_run = 0;
      else if (!was_run) begin m_run = 1; m_count = m_load; m_since = 0; end
      else m_run = 1;
    end
    if (idx == 1) m_load  = d;
    if (idx == 2) m_count = d;
    if (idx == 4) m_presc = d;
    if (idx == 3 && d[0]) m_tf = 0;
    if (expire) m_tf = 1;
    m_irq = next_irq;
  endtask

  // One bus cycle: queue what the outputs must show during it, then advance the model.
  task automatic cycle(input bit ena, input bit rw, input logic [31:0] a, input logic [15:0] d,
                       input bit rst, input bit use_c, input logic [15:0] c, input string tag);
    exp_t e;
    reset = rst; mem1_ena = ena; mem1_rw = rw; mem1_daddr = a; mem1_dout = d;
    e.rdata = use_c ? c : (ena ? m_read(a) : 16'h0);
    e.irq   = m_irq;
    e.tag   = tag;
    exp_q.push_back(e);
    m_step(ena, rw, a, d, rst);
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] off, input logic [15:0] d);
    cycle(1, 1, BASE + off, d, 0, 0, 16'h0, "wr");
  endtask

  task automatic rdc(input logic [31:0] a, input logic [15:0] c, input string tag);
    cycle(1, 0, a, 16'h0, 0, 1, c, tag);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check({e.tag, " din"}, mem1_din, e.rdata);
      check({e.tag, " irq"}, {15'd0, irq}, {15'd0, e.irq});
    end
  end

  initial begin
    logic [31:0] a;
    logic [15:0] d;
    int          r, k;

    reset = 1; mem1_ena = 0; mem1_rw = 0; mem1_daddr = '0; mem1_dout = '0;
    m_clear();
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    rdc(BASE + 32'h0,  16'h0, "rst ctrl");
    rdc(BASE + 32'h4,  16'h0, "rst load");
    rdc(BASE + 32'h8,  16'h0, "rst count");
    rdc(BASE + 32'hC,  16'h0, "rst status");
    rdc(BASE + 32'h10, 16'h0, "rst presc");
    cycle(0, 0, BASE, 16'h0, 0, 1, 16'h0, "ena0");

    // One-shot: LOAD=3, PRESCALE=0, EN
    wr(32'h4, 16'd3); wr(32'h10, 16'd0); wr(32'h0, 16'h1);
    rdc(BASE + 32'h8, 16'd3, "os c1");
    rdc(BASE + 32'h8, 16'd2, "os c2");
    rdc(BASE + 32'h9, 16'd1, "os c3");
    rdc(BASE + 32'hB, 16'd0, "os c4");
    rdc(BASE + 32'hC, 16'h1, "os tf");
    rdc(BASE + 32'h0, 16'h0, "os ctrl");
    rdc(BASE + 32'h8, 16'd0, "os hold");
    wr(32'hC, 16'h1);
    rdc(BASE + 32'hC, 16'h0, "os w1c");

    // Auto-reload with prescaler and interrupt
    wr(32'h4, 16'd2); wr(32'h10, 16'd1); wr(32'h0, 16'h7);
    rdc(BASE + 32'h8, 16'd2, "ar c1");
    rdc(BASE + 32'h8, 16'd2, "ar c2");
    rdc(BASE + 32'h8, 16'd1, "ar c3");
    rdc(BASE + 32'h8, 16'd1, "ar c4");
    rdc(BASE + 32'h8, 16'd0, "ar c5");
    rdc(BASE + 32'h8, 16'd0, "ar c6");
    rdc(BASE + 32'hC, 16'h1, "ar tf");
    rdc(BASE + 32'h8, 16'd2, "ar reload");
    wr(32'hC, 16'h1);
    rdc(BASE + 32'hC, 16'h0, "ar clr1");
    rdc(BASE + 32'hC, 16'h0, "ar clr2");
    wr(32'h0, 16'h0);

    // W1C colliding with an expiry tick
    wr(32'h4, 16'd1); wr(32'h10, 16'd0); wr(32'h0, 16'h3);
    rdc(BASE + 32'h8, 16'd1, "col c1");
    rdc(BASE + 32'h8, 16'd0, "col c2");
    rdc(BASE + 32'hC, 16'h1, "col tf");
    wr(32'hC, 16'h1);
    rdc(BASE + 32'hC, 16'h1, "col setwins");
    wr(32'h0, 16'h0);
    wr(32'hC, 16'h1);
    rdc(BASE + 32'hC, 16'h0, "col cleared");

    // Unmapped and below-base accesses
    rdc(BASE + 32'h14,  16'h0, "unmap rd");
    rdc(32'h0000_0FFC,  16'h0, "below rd");
    wr(32'h14, 16'hFFFF);
    cycle(1, 1, 32'h0000_0FFC, 16'hFFFF, 0, 0, 16'h0, "below wr");
    for (int i = 0; i < 5; i++) cycle(1, 0, BASE + 32'(4 * i), 16'h0, 0, 0, 16'h0, "unmap keep");

    // Reset in mid-run with TF and IE set
    wr(32'h4, 16'd0); wr(32'h10, 16'd0); wr(32'h0, 16'h7);
    rdc(BASE + 32'hC, 16'h0, "mr tf0");
    rdc(BASE + 32'hC, 16'h1, "mr tf1");
    wr(32'h4, 16'd9);
    wr(32'h8, 16'd5);
    cycle(1, 0, BASE + 32'h8, 16'h0, 1, 1, 16'd5, "mr cnt5");
    rdc(BASE + 32'h0,  16'h0, "mr ctrl");
    rdc(BASE + 32'h4,  16'h0, "mr load");
    rdc(BASE + 32'h8,  16'h0, "mr count");
    rdc(BASE + 32'hC,  16'h0, "mr status");
    rdc(BASE + 32'h10, 16'h0, "mr presc");

    // COUNT write against a tick
    wr(32'h4, 16'd10); wr(32'h0, 16'h1);
    wr(32'h8, 16'h00FF);
    rdc(BASE + 32'h8, 16'h00FF, "cw prio");
    wr(32'h0, 16'h0);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      a = BASE + 32'(4 * $urandom_range(0, 5)) + 32'($urandom_range(0, 3));
      if (r < 40) begin
        cycle(1, 0, a, 16'h0, 0, 0, 16'h0, "rnd rd");
      end else if (r < 48) begin
        cycle(0, 1'($urandom_range(0, 1)), a, 16'($urandom), 0, 0, 16'h0, "rnd idle");
      end else if (r < 50) begin
        cycle(1, 1'($urandom_range(0, 1)), 32'h0000_0FF0 + 32'($urandom_range(0, 15)),
              16'($urandom), 0, 0, 16'h0, "rnd below");
      end else if (r < 51) begin
        cycle(1, 0, a, 16'h0, 1, 0, 16'h0, "rnd rst");
      end else begin
        k = $urandom_range(0, 4);
        case (k)
          0, 3:    d = 16'($urandom);
          4:       d = 16'($urandom_range(0, 3));
          default: d = 16'($urandom_range(0, 6));
        endcase
        cycle(1, 1, BASE + 32'(4 * k), d, 0, 0, 16'h0, "rnd wr");
      end
    end

    mem1_ena = 0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
